// File: rtl/reg_write_queue_if.sv
// reg_write_queue_if: groups the writeback request channel, the register file
// write port, the read-port addresses and the bypass results.
//   in_valid/in_ready/in_addr/in_data : writeback request handshake
//   wr_hold                           : register file back-pressure
//   wr_en/addr3/data3                 : register file write port
//   addr1/addr2                       : register file read addresses
//   byp_hit1/2, byp_data1/2           : pending-write bypass for the read ports
// The master modport is the producer/register-file side. The slave modport is the queue.
interface reg_write_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          wr_hold;
    logic          wr_en;
    logic [AW-1:0] addr3;
    logic [DW-1:0] data3;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic          byp_hit1;
    logic          byp_hit2;
    logic [DW-1:0] byp_data1;
    logic [DW-1:0] byp_data2;

    modport master (
        output in_valid, in_addr, in_data, wr_hold, addr1, addr2,
        input  in_ready, wr_en, addr3, data3,
               byp_hit1, byp_hit2, byp_data1, byp_data2
    );

    modport slave (
        input  in_valid, in_addr, in_data, wr_hold, addr1, addr2,
        output in_ready, wr_en, addr3, data3,
               byp_hit1, byp_hit2, byp_data1, byp_data2
    );
endinterface

// File: rtl/reg_write_queue.sv
// reg_write_queue: in-order buffer of register writebacks in front of the
// 32x32 register file. It drains one entry per cycle onto addr3/data3 and
// supplies youngest-entry bypass data for read ports 1 and 2. Writes to
// register 0 complete the handshake but are dropped.
//   clk, reset : clock and synchronous active-high reset
//   bus        : reg_write_queue_if.slave (request, write port, bypass)
//   count      : current occupancy (0..DEPTH)
module reg_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    reg_write_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic push, pop, not_empty;
    ent_t head;

    assign not_empty    = !reset && (count_q != '0);
    assign head         = mem_q[rd_ptr_q];
    assign bus.in_ready = !reset && (count_q < CW'(DEPTH));
    assign bus.wr_en    = not_empty && !bus.wr_hold;
    // The head stays visible while held, so the register file sees a stable request.
    assign bus.addr3    = not_empty ? head.addr : '0;
    assign bus.data3    = not_empty ? head.data : '0;
    // count_q can still be nonzero during the reset cycle itself, so it is masked here.
    assign count        = reset ? '0 : count_q;

    assign push = bus.in_valid && bus.in_ready && (bus.in_addr != '0);
    assign pop  = bus.wr_en;

    // Walk the queue from oldest to youngest. The last match wins, which gives the
    // youngest pending value. An entry is valid when its distance from the head
    // is below the occupancy.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        for (int j = 0; j < DEPTH; j++) begin
            idx = rd_ptr_q + PW'(j);
            if (!reset && (a != '0) && (CW'(j) < count_q) && (mem_q[idx].addr == a))
                r = {1'b1, mem_q[idx].data};
        end
        return r;
    endfunction

    always_comb begin
        logic [DW:0] r1, r2;
        r1 = lookup(bus.addr1);
        r2 = lookup(bus.addr2);
        bus.byp_hit1  = r1[DW];
        bus.byp_data1 = r1[DW-1:0];
        bus.byp_hit2  = r2[DW];
        bus.byp_data2 = r2[DW-1:0];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{addr: bus.in_addr, data: bus.in_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry payloads need no reset. Validity comes only from count and rd_ptr,
    // so clearing count invalidates every entry.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_reg_write_queue.sv
module tb_reg_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic reset;
    logic [CW-1:0] count;
    always #5 clk = ~clk;

    reg_write_queue_if #(.AW(AW), .DW(DW)) bus();

    reg_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rdy;
        logic          wr;
        logic [AW-1:0] a3;
        logic [DW-1:0] d3;
        logic          h1;
        logic [DW-1:0] d1;
        logic          h2;
        logic [DW-1:0] d2;
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct {
        int   rst, v, a, d, h, a1, a2;
        out_t e;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    vec_t vt[23];

    function automatic vec_t mkv(int rst, int v, int a, int d, int h, int a1, int a2,
                                 int rdy, int wr, int a3, int d3, int h1, int d1,
                                 int h2, int d2, int cnt);
        vec_t r;
        r.rst = rst; r.v = v; r.a = a; r.d = d; r.h = h; r.a1 = a1; r.a2 = a2;
        r.e.rdy = rdy[0]; r.e.wr = wr[0]; r.e.a3 = a3[AW-1:0]; r.e.d3 = d3;
        r.e.h1 = h1[0]; r.e.d1 = d1; r.e.h2 = h2[0]; r.e.d2 = d2; r.e.cnt = cnt[CW-1:0];
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(string tag, out_t e);
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(e.rdy));
        chk({tag, ".wr_en"},     32'(bus.wr_en),     32'(e.wr));
        chk({tag, ".addr3"},     32'(bus.addr3),     32'(e.a3));
        chk({tag, ".data3"},     bus.data3,          e.d3);
        chk({tag, ".byp_hit1"},  32'(bus.byp_hit1),  32'(e.h1));
        chk({tag, ".byp_data1"}, bus.byp_data1,      e.d1);
        chk({tag, ".byp_hit2"},  32'(bus.byp_hit2),  32'(e.h2));
        chk({tag, ".byp_data2"}, bus.byp_data2,      e.d2);
        chk({tag, ".count"},     32'(count),         32'(e.cnt));
    endtask

    // Reference: the queue is a list of pending writes, oldest first.
    function automatic out_t model_out();
        out_t o;
        int   n;
        n = mq.size();
        o = '{default: '0};
        if (!reset) begin
            o.rdy = (n < DEPTH);
            o.wr  = (n != 0) && !bus.wr_hold;
            if (n != 0) begin
                o.a3 = mq[0].a;
                o.d3 = mq[0].d;
            end
            o.cnt = CW'(n);
            for (int i = n - 1; i >= 0; i--)
                if (bus.addr1 != 0 && mq[i].a == bus.addr1) begin
                    o.h1 = 1'b1; o.d1 = mq[i].d; break;
                end
            for (int i = n - 1; i >= 0; i--)
                if (bus.addr2 != 0 && mq[i].a == bus.addr2) begin
                    o.h2 = 1'b1; o.d2 = mq[i].d; break;
                end
        end
        return o;
    endfunction

    task automatic drive(int rst, int v, int a, int d, int h, int a1, int a2);
        reset        = rst[0];
        bus.in_valid = v[0];
        bus.in_addr  = a[AW-1:0];
        bus.in_data  = d;
        bus.wr_hold  = h[0];
        bus.addr1    = a1[AW-1:0];
        bus.addr2    = a2[AW-1:0];
        #3;
    endtask

    // Advance one clock and update the reference with the transfer and commit
    // decisions implied by the inputs of the cycle just ending.
    task automatic finish_cycle();
        bit   acc, pp, rs;
        ent_t e;
        rs  = reset;
        acc = !reset && bus.in_valid && (mq.size() < DEPTH) && (bus.in_addr != 0);
        pp  = !reset && (mq.size() != 0) && !bus.wr_hold;
        e.a = bus.in_addr;
        e.d = bus.in_data;
        @(posedge clk);
        if (rs) mq.delete();
        else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        #1;
    endtask

    initial begin
        vt[0]  = mkv(1,0,0,0,0,0,0,          0,0,0,0,0,0,0,0,0);
        vt[1]  = mkv(0,1,5,'h1234,0,5,0,     1,0,0,0,0,0,0,0,0);
        vt[2]  = mkv(0,0,0,0,0,5,0,          1,1,5,'h1234,1,'h1234,0,0,1);
        vt[3]  = mkv(0,0,0,0,0,5,0,          1,0,0,0,0,0,0,0,0);
        vt[4]  = mkv(0,1,0,'hDEAD,0,0,0,     1,0,0,0,0,0,0,0,0);
        vt[5]  = mkv(0,0,0,0,0,0,0,          1,0,0,0,0,0,0,0,0);
        vt[6]  = mkv(0,1,7,'hA,1,7,0,        1,0,0,0,0,0,0,0,0);
        vt[7]  = mkv(0,1,7,'hB,1,7,0,        1,0,7,'hA,1,'hA,0,0,1);
        vt[8]  = mkv(0,0,0,0,1,7,0,          1,0,7,'hA,1,'hB,0,0,2);
        vt[9]  = mkv(0,0,0,0,0,7,0,          1,1,7,'hA,1,'hB,0,0,2);
        vt[10] = mkv(0,0,0,0,0,7,0,          1,1,7,'hB,1,'hB,0,0,1);
        vt[11] = mkv(0,0,0,0,0,7,0,          1,0,0,0,0,0,0,0,0);
        vt[12] = mkv(0,1,1,'h11,1,0,0,       1,0,0,0,0,0,0,0,0);
        vt[13] = mkv(0,1,2,'h22,1,0,0,       1,0,1,'h11,0,0,0,0,1);
        vt[14] = mkv(0,1,3,'h33,0,3,1,       1,1,1,'h11,0,0,1,'h11,2);
        vt[15] = mkv(0,0,0,0,0,3,1,          1,1,2,'h22,1,'h33,0,0,2);
        vt[16] = mkv(0,0,0,0,0,3,0,          1,1,3,'h33,1,'h33,0,0,1);
        vt[17] = mkv(0,0,0,0,0,3,0,          1,0,0,0,0,0,0,0,0);
        vt[18] = mkv(0,1,4,'h44,1,4,5,       1,0,0,0,0,0,0,0,0);
        vt[19] = mkv(0,1,5,'h55,1,4,5,       1,0,4,'h44,1,'h44,0,0,1);
        vt[20] = mkv(0,1,6,'h66,1,4,5,       1,0,4,'h44,1,'h44,1,'h55,2);
        vt[21] = mkv(1,0,0,0,0,4,5,          0,0,0,0,0,0,0,0,0);
        vt[22] = mkv(0,0,0,0,0,4,5,          1,0,0,0,0,0,0,0,0);

        drive(1,0,0,0,0,0,0);
        @(posedge clk); #1;

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].v, vt[i].a, vt[i].d, vt[i].h, vt[i].a1, vt[i].a2);
            compare($sformatf("vec%0d", i), vt[i].e);
            finish_cycle();
        end

        // Fill under hold: four accepted, fifth stalls until the first pop.
        for (int i = 1; i <= 4; i++) begin
            drive(0,1,i,i*256,1,0,0);
            chk($sformatf("fill%0d.in_ready", i), 32'(bus.in_ready), 1);
            finish_cycle();
        end
        drive(0,1,5,'h500,1,0,0);
        chk("full.in_ready", 32'(bus.in_ready), 0);
        chk("full.count", 32'(count), 4);
        chk("full.wr_en", 32'(bus.wr_en), 0);
        finish_cycle();
        drive(0,1,5,'h500,0,0,0);
        chk("release.in_ready", 32'(bus.in_ready), 0);
        chk("release.wr_en", 32'(bus.wr_en), 1);
        chk("release.addr3", 32'(bus.addr3), 1);
        chk("release.data3", bus.data3, 'h100);
        finish_cycle();
        for (int k = 2; k <= 5; k++) begin
            drive(0, (k == 2) ? 1 : 0, 5, 'h500, 0, 0, 0);
            if (k == 2) chk("refill.in_ready", 32'(bus.in_ready), 1);
            chk($sformatf("drain%0d.wr_en", k), 32'(bus.wr_en), 1);
            chk($sformatf("drain%0d.addr3", k), 32'(bus.addr3), 32'(k));
            chk($sformatf("drain%0d.data3", k), bus.data3, 32'(k * 256));
            finish_cycle();
        end
        drive(0,0,0,0,0,0,0);
        chk("drained.count", 32'(count), 0);
        chk("drained.wr_en", 32'(bus.wr_en), 0);
        finish_cycle();

        // Randomized traffic against the reference queue.
        drive(1,0,0,0,0,0,0);
        compare("rand_rst", model_out());
        finish_cycle();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 39) == 0) ? 1 : 0,
                  ($urandom_range(0, 9) < 7) ? 1 : 0,
                  int'($urandom_range(0, 7)), int'($urandom),
                  ($urandom_range(0, 9) < 3) ? 1 : 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            compare($sformatf("rand%0d", n), model_out());
            finish_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

Write-side companion to the 32×32 MIPS register file. Buffers register writeback results (ALU or load data) in a small in-order queue and drains them one per cycle onto the register file write port (`wr_en`/`addr3`/`data3`). It also supplies youngest-entry bypass data to the two read ports (`addr1`/`addr2`), so readers see results that are queued but not yet committed. Writes to register 0 are discarded.

## Interface
- `DEPTH`, 4, number of queue entries (power of two, ≥2)
- `AW`, 5, register address width
- `DW`, 32, register data width

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  writeback request valid
- `in_ready`  out  1  queue can accept; transfer when `in_valid && in_ready`
- `in_addr`  in  AW  destination register
- `in_data`  in  DW  value to write
- `wr_hold`  in  1  register file not accepting; head is not popped
- `wr_en`  out  1  write strobe to register file
- `addr3`  out  AW  write address to register file
- `data3`  out  DW  write data to register file
- `addr1`, `addr2`  in  AW  read addresses presented to register file
- `byp_hit1`, `byp_hit2`  out  1  queued write pending for `addr1`/`addr2`
- `byp_data1`, `byp_data2`  out  DW  youngest queued value for `addr1`/`addr2`
- `count`  out  log2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: `DEPTH` entries of {addr, data}, with `wr_ptr`, `rd_ptr`, and `count`. Pointers wrap modulo `DEPTH`.
- Enqueue on accepted transfer with `in_addr != 0`.
  - A transfer with `in_addr == 0` is accepted (handshake completes) but nothing is enqueued.
- `in_ready = !reset && (count < DEPTH)`. There is no pass-through when full, even if a pop occurs in the same cycle.
- Commit: `wr_en = (count != 0) && !wr_hold`.
  - `addr3`/`data3` = head entry when `count != 0`, else 0.
  - Head is popped at the edge where `wr_en` is high.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Order is strictly FIFO. Multiple entries to the same register all commit in order, with no coalescing.
- Bypass (combinational) for port k:
  - `byp_hitk` = 1 if any valid entry has addr == `addrk` and `addrk != 0`.
  - `byp_datak` = data of the youngest such entry, else 0.
  - The entry at the head being written this cycle still counts as a hit.
  - A transfer arriving this cycle (not yet enqueued) does not count as a hit.
- `wr_hold` high: queue contents and outputs are frozen except for enqueues. `wr_en` = 0.

## Timing
- Reset (sync): at the edge with `reset` = 1, `count`, `wr_ptr`, `rd_ptr` ← 0 and all entries are invalidated.
  - While `reset` is high and in the cycle after: `wr_en` = 0, `addr3` = 0, `data3` = 0, `byp_hit*` = 0, `byp_data*` = 0, `count` = 0.
  - `in_ready` = 0 while `reset` is high and 1 in the first cycle after.
- Reset mid-operation discards all queued writes; no `wr_en` is issued for them.
- Latency: with the queue empty, a transfer accepted at edge T gives `wr_en` = 1 with its addr/data during cycle T→T+1. The register file captures it at edge T+1.
- Throughput: one enqueue and one commit per cycle sustained, provided `wr_hold` = 0.
- Full: `count == DEPTH` → `in_ready` = 0. The queue stays full until a pop, and `in_ready` returns to 1 in the cycle after the pop edge.
- Empty with `wr_hold` = 0: `wr_en` = 0 and no pop occurs.

## Test plan
- Reset then single write: enqueue (addr 5, 0x1234) at edge 1 → `wr_en` = 1, `addr3` = 5, `data3` = 0x1234 during cycle 1–2; `count` returns to 0 after edge 2.
- Register 0 drop: enqueue (0, 0xDEAD) → `in_ready` handshake completes, `count` stays 0, `wr_en` never asserts.
- Fill under hold: `wr_hold` = 1, send 5 writes to regs 1..5 → first 4 accepted, `count` = 4, `in_ready` = 0 on the 5th. Release hold → regs 1,2,3,4 commit on 4 consecutive cycles; the 5th is accepted the cycle after the first pop.
- Bypass youngest: `wr_hold` = 1, enqueue (7, 0xA) then (7, 0xB); `addr1` = 7, `addr2` = 0 → `byp_hit1` = 1, `byp_data1` = 0xB, `byp_hit2` = 0.
- Simultaneous push/pop at `count` = 2: enqueue and commit in the same cycle → `count` remains 2 and the commit order is preserved.
- Mid-operation reset: 3 entries queued, assert `reset` for 1 cycle → no further `wr_en`, `count` = 0, all `byp_hit*` = 0, `in_ready` = 1 in the next cycle.
